alu_issue_ctrl: RTL and testbench

//  Drives the 64-bit ALU's control/operand interface from decode and returns results to writeback.
//  - Accepts decoded ops through a valid/ready handshake.
//  - Encodes the 4-bit ALU control code: AND 0000, OR 0001, ADD 0010, SUB 0110.
//  - Holds operands stable for one execute cycle, captures the ALU result, then presents it with valid/ready.
//  - Sits between the decode stage and the ALU; the ALU itself is combinational.

---
 rtl/alu_issue_ctrl_if.sv | 49 ++++
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Bundles the decode-side handshake, the ALU operand/control/result bus and
//   the writeback-side handshake of alu_issue_ctrl.
//   Modports:
//     slave  - issue controller view (alu_issue_ctrl)
//     master - environment view (decode, ALU and writeback; used by the bench)
//   Optional macro ALU_ZERO_FLAG_EN adds res_zero.
interface alu_issue_ctrl_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [2:0]   funct3;
  logic         funct7_5;
  logic [N-1:0] rs1_data;
  logic [N-1:0] rs2_data;
  logic [N-1:0] input_data_1;
  logic [N-1:0] input_data_2;
  logic [3:0]   control;
  logic [N-1:0] output_data;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_illegal;
`ifdef ALU_ZERO_FLAG_EN
  logic         res_zero;
`endif

  modport slave (
`ifdef ALU_ZERO_FLAG_EN
    output res_zero,
`endif
    input  in_valid, alu_op, funct3, funct7_5, rs1_data, rs2_data,
    input  output_data, res_ready,
    output in_ready, input_data_1, input_data_2, control,
    output res_valid, res_data, res_illegal
  );

  modport master (
`ifdef ALU_ZERO_FLAG_EN
    input  res_zero,
`endif
    output in_valid, alu_op, funct3, funct7_5, rs1_data, rs2_data,
    output output_data, res_ready,
    input  in_ready, input_data_1, input_data_2, control,
    input  res_valid, res_data, res_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issues decoded ops to a combinational ALU: decodes the 4-bit ALU control
//   code, holds operands for one execute cycle, captures the ALU result and
//   presents it to writeback with a valid/ready handshake.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - alu_issue_ctrl_if.slave (decode handshake, ALU bus, result handshake)
//   Optional macro ALU_ZERO_FLAG_EN: adds bus.res_zero = (res_data == 0),
//   registered together with res_data.
//
//   state | meaning
//   IDLE  | no op in flight, ready for decode
//   EXEC  | operands/control driving the ALU, result captured at next edge
//   DONE  | result presented to writeback until taken
module alu_issue_ctrl #(
  parameter int n = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_BAD = 4'b1111;

  state_t       r_state;
  state_t       w_next;
  logic         w_in_ready;
  logic         w_accept;
  logic [3:0]   w_ctrl;
  logic         w_illegal;

  logic [n-1:0] r_op1;
  logic [n-1:0] r_op2;
  logic [3:0]   r_ctrl;
  logic         r_illegal;
  logic         r_res_valid;
  logic [n-1:0] r_res_data;
  logic         r_res_illegal;
  logic [n-1:0] w_res_next;

  // decode
  always_comb begin
    w_ctrl    = C_BAD;
    w_illegal = 1'b1;
    unique case (bus.alu_op)
      2'b00: begin w_ctrl = C_ADD; w_illegal = 1'b0; end
      2'b01: begin w_ctrl = C_SUB; w_illegal = 1'b0; end
      2'b10: begin
        unique case (bus.funct3)
          3'b000: begin w_ctrl = bus.funct7_5 ? C_SUB : C_ADD; w_illegal = 1'b0; end
          3'b111: begin w_ctrl = C_AND; w_illegal = 1'b0; end
          3'b110: begin w_ctrl = C_OR;  w_illegal = 1'b0; end
          default: begin w_ctrl = C_BAD; w_illegal = 1'b1; end
        endcase
      end
      default: begin w_ctrl = C_BAD; w_illegal = 1'b1; end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_EXEC;
      S_EXEC: w_next = S_DONE;
      S_DONE: if (bus.res_ready) w_next = bus.in_valid ? S_EXEC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs; in DONE the slot frees in the same cycle writeback takes the result
  always_comb begin
    w_in_ready = 1'b0;
    unique case (r_state)
      S_IDLE:  w_in_ready = 1'b1;
      S_DONE:  w_in_ready = bus.res_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_accept   = bus.in_valid & w_in_ready;
  // illegal ops never expose whatever the ALU makes of control 1111
  assign w_res_next = r_illegal ? '0 : bus.output_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1         <= '0;
      r_op2         <= '0;
      r_ctrl        <= C_AND;
      r_illegal     <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op1     <= bus.rs1_data;
        r_op2     <= bus.rs2_data;
        r_ctrl    <= w_ctrl;
        r_illegal <= w_illegal;
      end
      if (r_state == S_EXEC) begin
        r_res_valid   <= 1'b1;
        r_res_data    <= w_res_next;
        r_res_illegal <= r_illegal;
      end else if (r_state == S_DONE && bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  logic r_res_zero;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_res_zero <= 1'b0;
    else if (r_state == S_EXEC) r_res_zero <= (w_res_next == '0);
  end
  assign bus.res_zero = r_res_zero;
`endif

  assign bus.in_ready     = w_in_ready;
  assign bus.input_data_1 = r_op1;
  assign bus.input_data_2 = r_op2;
  assign bus.control      = r_ctrl;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.res_illegal  = r_res_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_issue_ctrl_if #(.N(64)) bus ();

  alu_issue_ctrl #(.n(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational ALU; an unknown code yields a nonzero pattern
  always_comb begin
    case (bus.control)
      4'b0000: bus.output_data = bus.input_data_1 & bus.input_data_2;
      4'b0001: bus.output_data = bus.input_data_1 | bus.input_data_2;
      4'b0010: bus.output_data = bus.input_data_1 + bus.input_data_2;
      4'b0110: bus.output_data = bus.input_data_1 - bus.input_data_2;
      default: bus.output_data = 64'hA5A5_5A5A_DEAD_BEEF;
    endcase
  end

  // reference: classify the instruction, then compute what writeback must see
  function automatic void ref_model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [3:0] ctrl, output logic [63:0] res,
                                    output logic ill);
    string kind;
    if (op == 2'd0)                    kind = "add";
    else if (op == 2'd1)               kind = "sub";
    else if (op == 2'd2 && f3 == 3'd0) kind = f7 ? "sub" : "add";
    else if (op == 2'd2 && f3 == 3'd7) kind = "and";
    else if (op == 2'd2 && f3 == 3'd6) kind = "or";
    else                               kind = "bad";
    ill = 1'b0;
    case (kind)
      "add":   begin ctrl = 4'd2; res = a + b; end
      "sub":   begin ctrl = 4'd6; res = a - b; end
      "and":   begin ctrl = 4'd0; res = a & b; end
      "or":    begin ctrl = 4'd1; res = a | b; end
      default: begin ctrl = 4'hF; res = 64'd0; ill = 1'b1; end
    endcase
  endfunction

  task automatic drive_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [63:0] a, input logic [63:0] b);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
    bus.rs1_data = a;
    bus.rs2_data = b;
  endtask

  // present op at a negedge, let one rising edge accept it, then withdraw it
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    drive_op(op, f3, f7, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== 64'd0 || bus.control !== 4'd0 ||
        bus.input_data_1 !== 64'd0 || bus.input_data_2 !== 64'd0 || bus.res_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b data=%h ctrl=%h op1=%h op2=%h ill=%0b, want all 0",
               bus.res_valid, bus.res_data, bus.control, bus.input_data_1, bus.input_data_2, bus.res_illegal);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    issue(2'd2, 3'd0, 1'b0, 64'd9, 64'd3);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_exec_busy: in_ready %0b want 0", bus.in_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== 64'd0 || bus.control !== 4'd0 ||
        bus.input_data_1 !== 64'd0 || bus.input_data_2 !== 64'd0 || bus.res_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_exec: valid=%0b data=%h ctrl=%h op1=%h op2=%h, want all 0",
               bus.res_valid, bus.res_data, bus.control, bus.input_data_1, bus.input_data_2);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_no_stale: cyc %0d valid=%0b ready=%0b want 0/1", i, bus.res_valid, bus.in_ready);
      end
    end
  endtask

  // one directed op from IDLE through result and handoff
  task automatic test_directed(input string name, input logic [1:0] op, input logic [2:0] f3,
                               input logic f7, input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] want_ctrl, input logic [63:0] want_res,
                               input logic want_ill);
    bus.res_ready = 1'b0;
    issue(op, f3, f7, a, b);
    checks++;
    if (bus.control !== want_ctrl || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: ctrl=%h valid=%0b want ctrl=%h valid=0", name, bus.control, bus.res_valid, want_ctrl);
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== want_res || bus.res_illegal !== want_ill) begin
      errors++;
      $display("FAIL %s_res: valid=%0b data=%h ill=%0b want 1 %h %0b", name, bus.res_valid, bus.res_data,
               bus.res_illegal, want_res, want_ill);
    end
`ifdef ALU_ZERO_FLAG_EN
    checks++;
    if (bus.res_zero !== (want_res == 64'd0)) begin
      errors++;
      $display("FAIL %s_zero: got %0b want %0b", name, bus.res_zero, want_res == 64'd0);
    end
`endif
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_take: valid=%0b ready=%0b want 0/1", name, bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] d;
    bus.res_ready = 1'b0;
    issue(2'd2, 3'd0, 1'b1, 64'd100, 64'd40);
    @(negedge clk);
    drive_op(2'd2, 3'd6, 1'b0, 64'h0F, 64'hF0);  // must stall behind the pending result
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 64'd60 || bus.in_ready !== 1'b0 ||
          bus.input_data_1 !== 64'd100 || bus.input_data_2 !== 64'd40 || bus.control !== 4'd6) begin
        errors++;
        $display("FAIL bp_hold: cyc %0d valid=%0b data=%h ready=%0b op1=%h op2=%h ctrl=%h", i,
                 bus.res_valid, bus.res_data, bus.in_ready, bus.input_data_1, bus.input_data_2, bus.control);
      end
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %0b want 0", bus.in_ready); end
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %0b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.control !== 4'd1 || bus.input_data_1 !== 64'h0F) begin
      errors++;
      $display("FAIL b2b_accept: valid=%0b ctrl=%h op1=%h want 0 1 f", bus.res_valid, bus.control, bus.input_data_1);
    end
    @(negedge clk);
    d = bus.res_data;
    checks++;
    if (bus.res_valid !== 1'b1 || d !== 64'hFF) begin
      errors++;
      $display("FAIL b2b_res: valid=%0b data=%h want 1 ff", bus.res_valid, d);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  // random ops, random backpressure, random back-to-back chaining
  task automatic test_random;
    logic [1:0] op; logic [2:0] f3; logic f7; logic [63:0] a, b;
    logic [3:0] ec; logic [63:0] er; logic ei;
    int stall;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      f3 = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(6, 7));
      f7 = 1'($urandom);
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      ref_model(op, f3, f7, a, b, ec, er, ei);
      @(negedge clk);
      drive_op(op, f3, f7, a, b);
      bus.res_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready: op %0d got %0b want 1", n, bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.res_ready = 1'b0;
      checks++;
      if (bus.control !== ec || bus.input_data_1 !== a || bus.input_data_2 !== b ||
          bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL rnd_exec: op %0d ctrl=%h want %h valid=%0b ready=%0b", n, bus.control, ec,
                 bus.res_valid, bus.in_ready);
      end
      @(negedge clk);
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        if (s > 0) @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== er || bus.res_illegal !== ei ||
            bus.control !== ec || bus.input_data_1 !== a) begin
          errors++;
          $display("FAIL rnd_result: op %0d s %0d valid=%0b data=%h want %h ill=%0b want %0b", n, s,
                   bus.res_valid, bus.res_data, er, bus.res_illegal, ei);
        end
`ifdef ALU_ZERO_FLAG_EN
        checks++;
        if (bus.res_zero !== (er == 64'd0)) begin
          errors++;
          $display("FAIL rnd_zero: op %0d got %0b want %0b", n, bus.res_zero, er == 64'd0);
        end
`endif
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL rnd_idle: op %0d valid=%0b ready=%0b want 0/1", n, bus.res_valid, bus.in_ready);
        end
      end
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    bus.alu_op    = 2'd0;
    bus.funct3    = 3'd0;
    bus.funct7_5  = 1'b0;
    bus.rs1_data  = 64'd0;
    bus.rs2_data  = 64'd0;
    rst_n         = 1'b1;
    #2;
    test_reset;
    test_directed("add",     2'd2, 3'd0, 1'b0, 64'd5,     64'd7,     4'b0010, 64'd12,     1'b0);
    test_directed("sub_wrap",2'd1, 3'd0, 1'b0, 64'd0,     64'd1,     4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    test_directed("and",     2'd2, 3'd7, 1'b0, 64'hF0F0, 64'hFF00, 4'b0000, 64'hF000,   1'b0);
    test_directed("or",      2'd2, 3'd6, 1'b0, 64'hF0F0, 64'hFF00, 4'b0001, 64'hFFF0,   1'b0);
    test_directed("ldst",    2'd0, 3'd5, 1'b1, 64'd30,    64'd12,    4'b0010, 64'd42,     1'b0);
    test_directed("illegal", 2'd3, 3'd0, 1'b0, 64'd5,     64'd7,     4'b1111, 64'd0,      1'b1);
    test_directed("bad_f3",  2'd2, 3'd1, 1'b0, 64'd5,     64'd7,     4'b1111, 64'd0,      1'b1);
    test_backpressure;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
